risc_fetch_buffer: RTL and testbench

Instruction fetch front end for the `risc` core: owns the fetch PC, issues word requests to instruction memory, and buffers returned instructions with their PCs in a small FIFO for the decode stage. It sits directly upstream of decode and is the first stage to leave reset. Branch/jump redirects from execute flush the buffer and discard stale in-flight responses.

---
 rtl/risc_fetch_buffer_if.sv | 36 +++
 rtl/risc_fetch_buffer.sv | 154 +++++++++++++++
 tb/tb_risc_fetch_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/risc_fetch_buffer_if.sv
// Fetch-buffer bus: instruction-memory request/response, execute redirect and decode handoff.
// Defining FETCH_MISALIGN_TRAP_EN adds the if_misalign flag to the decode side.
interface risc_fetch_buffer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, if_ready
`ifdef FETCH_MISALIGN_TRAP_EN
        , output if_misalign
`endif
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, if_ready
`ifdef FETCH_MISALIGN_TRAP_EN
        , input if_misalign
`endif
    );
endinterface

// File: rtl/risc_fetch_buffer.sv
// Fetch front end: owns the fetch PC, issues word requests under a credit limit and buffers {pc, instr} for decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and present one trap entry.
module risc_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    risc_fetch_buffer_if.master bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];

    logic          w_redirect;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_rsp_keep;
    logic          w_push;
    logic          w_pop;
    logic          w_if_valid;
    logic          w_halt;
    logic          w_trap_push;
    logic [31:0]   w_redirect_pc;
    logic [31:0]   w_push_pc;
    logic [31:0]   w_push_instr;
    logic [CW:0]   w_occ;
    logic [CW-1:0] w_inflight_nxt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic             r_halt;
    logic             r_trap_pending;
    logic [DEPTH-1:0] r_mem_mis;

    assign w_redirect_pc   = bus.redirect_pc;
    assign w_halt          = r_halt;
    assign w_trap_push     = r_trap_pending && (r_inflight == '0) && !w_redirect;
    assign bus.if_misalign = w_if_valid ? r_mem_mis[r_rd_ptr] : 1'b0;

    // Misaligned redirect halts fetch and arms one trap entry once stale responses drain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_halt         <= 1'b0;
            r_trap_pending <= 1'b0;
            r_mem_mis      <= '0;
        end else begin
            if (w_redirect) begin
                r_halt         <= |bus.redirect_pc[1:0];
                r_trap_pending <= |bus.redirect_pc[1:0];
            end else if (w_trap_push) begin
                r_trap_pending <= 1'b0;
            end
            if (w_push) begin
                r_mem_mis[r_wr_ptr] <= w_trap_push;
            end
        end
    end
`else
    logic w_unused;

    // Without the trap feature the low redirect bits are simply discarded
    assign w_unused      = ^bus.redirect_pc[1:0];
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
    assign w_halt        = 1'b0;
    assign w_trap_push   = 1'b0;
`endif

    // Credit rule: buffered plus in-flight never exceeds DEPTH, so a push always has room
    assign w_redirect     = bus.redirect_valid;
    assign w_occ          = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_req_valid    = reset && !w_redirect && !w_halt && (w_occ < DEPTH_W);
    assign w_req_fire     = w_req_valid && bus.imem_req_ready;
    assign w_rsp_keep     = bus.imem_rsp_valid && (r_discard == '0) && !w_redirect;
    assign w_push         = w_rsp_keep || w_trap_push;
    assign w_if_valid     = (r_count != '0);
    assign w_pop          = w_if_valid && bus.if_ready && !w_redirect;
    assign w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(bus.imem_rsp_valid);

    // Select the entry written this cycle: a fetched word or the misalign trap NOP
    always_comb begin
        w_push_pc    = r_rsp_pc;
        w_push_instr = bus.imem_rsp_data;
        if (w_trap_push) begin
            w_push_pc    = r_fetch_pc;
            w_push_instr = 32'h0000_0013;
        end else begin
            w_push_pc    = r_rsp_pc;
            w_push_instr = bus.imem_rsp_data;
        end
    end

    // PC tracking, credit counters and FIFO storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_pc[i]    <= 32'h0000_0000;
                r_mem_instr[i] <= 32'h0000_0000;
            end
        end else begin
            r_inflight <= w_inflight_nxt;
            if (w_redirect) begin
                // Everything still outstanding after this cycle belongs to the old path
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_discard  <= w_inflight_nxt;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_keep) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (bus.imem_rsp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_mem_pc[r_wr_ptr]    <= w_push_pc;
                    r_mem_instr[r_wr_ptr] <= w_push_instr;
                    r_wr_ptr              <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_fetch_pc;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_instr       = w_if_valid ? r_mem_instr[r_rd_ptr] : 32'h0000_0000;
    assign bus.if_pc          = w_if_valid ? r_mem_pc[r_rd_ptr] : 32'h0000_0000;
endmodule

// File: tb/tb_risc_fetch_buffer.sv
// Randomized bench for risc_fetch_buffer: in-order memory model with variable latency and a
// stream-level reference (each redirect starts a new PC stream; stale responses never surface).
module tb_risc_fetch_buffer;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    risc_fetch_buffer_if bus ();

    risc_fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        memq[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          epoch = 0;
    int          nbuf  = 0;
    int          pops  = 0;
    int          lat   = 1;
    int          rdy_pct = 100;
    int          ack_pct = 100;
    bit          halted  = 1'b0;
    bit          trap_pending = 1'b0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] exp_req_addr = RESET_PC;
    logic [31:0] exp_pop_pc   = RESET_PC;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b0;
    endtask

    // Called at a falling edge; leaves the bench at a falling edge with reset released
    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_req_valid", bus.imem_req_valid, 1'b0);
        check_eq("rst_addr",      bus.imem_addr,      RESET_PC);
        check_eq("rst_if_valid",  bus.if_valid,       1'b0);
        check_eq("rst_if_instr",  bus.if_instr,       32'h0);
        check_eq("rst_if_pc",     bus.if_pc,          32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("rst_misalign",  bus.if_misalign,    1'b0);
`endif
        memq.delete();
        nbuf         = 0;
        epoch++;
        exp_req_addr = RESET_PC;
        exp_pop_pc   = RESET_PC;
        halted       = 1'b0;
        trap_pending = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, sample before the rising edge, update the model after it
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit          rsp;
        bit          kept;
        bit          fire;
        bit          popped;
        bit          trap_push;
        logic [31:0] rpc_eff;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.if_ready       = ($urandom_range(99, 0) < rdy_pct);
        bus.imem_req_ready = ($urandom_range(99, 0) < ack_pct);
        rsp                = (memq.size() > 0) && (memq[0].due <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? (memq[0].addr ^ KEY) : $urandom;
        #1;
        check_eq("if_valid",  bus.if_valid, nbuf != 0);
        check_eq("req_valid", bus.imem_req_valid, !redir && !halted && (memq.size() + nbuf < DEPTH));
        check_eq("credit",    (memq.size() + nbuf) <= DEPTH, 1'b1);
        fire = bus.imem_req_valid && bus.imem_req_ready;
        if (fire) begin
            check_eq("req_addr", bus.imem_addr, exp_req_addr);
        end
        popped = bus.if_valid && bus.if_ready && !redir;
        if (popped) begin
            if (halted) begin
                check_eq("trap_pc",    bus.if_pc,    trap_pc);
                check_eq("trap_instr", bus.if_instr, 32'h0000_0013);
`ifdef FETCH_MISALIGN_TRAP_EN
                check_eq("trap_flag",  bus.if_misalign, 1'b1);
`endif
            end else begin
                check_eq("if_pc",    bus.if_pc,    exp_pop_pc);
                check_eq("if_instr", bus.if_instr, exp_pop_pc ^ KEY);
`ifdef FETCH_MISALIGN_TRAP_EN
                check_eq("if_misalign", bus.if_misalign, 1'b0);
`endif
                exp_pop_pc = exp_pop_pc + 32'd4;
            end
        end
        kept      = rsp && !redir && (memq[0].epoch == epoch);
        trap_push = trap_pending && (memq.size() == 0) && !redir;
        @(posedge clk);
        cyc++;
        if (rsp) begin
            void'(memq.pop_front());
        end
        if (fire) begin
            memq.push_back('{addr: exp_req_addr, due: cyc + lat - 1, epoch: epoch});
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            rpc_eff      = rpc;
            halted       = (rpc[1:0] != 2'b00);
            trap_pending = halted;
            trap_pc      = rpc;
`else
            rpc_eff      = {rpc[31:2], 2'b00};
`endif
            epoch++;
            nbuf         = 0;
            exp_req_addr = rpc_eff;
            exp_pop_pc   = rpc_eff;
        end else begin
            nbuf = nbuf + int'(kept) + int'(trap_push) - int'(popped);
            if (trap_push) begin
                trap_pending = 1'b0;
            end
        end
        if (popped) begin
            pops++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 32'h0);
        end
    endtask

    initial begin
        int          base;
        logic [31:0] rpc;
        drive_idle();
        @(negedge clk);
        do_reset();

        // Wrap-around start, 1-cycle memory, decode always ready: one instruction per cycle
        lat = 1; rdy_pct = 100; ack_pct = 100;
        run(4);
        base = pops;
        run(20);
        check_eq("throughput", pops - base, 20);

        // Decode stall: credit fills to DEPTH and requests stop
        rdy_pct = 0;
        run(10);
        check_eq("stall_occ", memq.size() + nbuf, DEPTH);
        rdy_pct = 100;
        run(10);

        // Slow memory, redirect with responses in flight
        lat = 3;
        run(8);
        check_eq("inflight_before_redir", memq.size() > 1, 1'b1);
        cycle(1'b1, 32'h0000_0100);
        run(12);

        // Redirect in steady state, coincident with a response and a pop
        lat = 1;
        run(6);
        cycle(1'b1, 32'h0000_0200);
        run(8);

        // Misaligned redirect
        base = pops;
        cycle(1'b1, 32'h0000_0102);
        run(12);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("trap_once", pops - base, 1);
`else
        check_eq("misalign_forced", pops - base > 5, 1'b1);
`endif
        cycle(1'b1, 32'h0000_0300);
        run(6);

        // Random traffic, including a mid-run reset
        rdy_pct = 70; ack_pct = 70;
        for (int i = 0; i < 1200; i++) begin
            lat = $urandom_range(4, 1);
            if (i == 600) begin
                do_reset();
            end
            if ($urandom_range(99, 0) < 5) begin
                rpc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
                if ($urandom_range(9, 0) != 0) begin
                    rpc[1:0] = 2'b00;
                end
`endif
                cycle(1'b1, rpc);
            end else begin
                cycle(1'b0, 32'h0);
            end
        end
        rdy_pct = 100; ack_pct = 100;
        cycle(1'b1, 32'hFFFF_FFFC);
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
